seq_stat_engine: RTL and testbench

SEQ_STAT_ENGINE -- requirements
Module: seq_stat_engine

---
 rtl/seq_stat_engine.sv | 220 ++++++++++++++++++++++
 tb/tb_seq_stat_engine.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_stat_engine.sv
// seq_stat_engine
// ---------------
// Collects a frame of NUM unsigned samples and produces one of four
// statistics selected by the mode captured on the first sample of the frame.
//
// Handshake: in_valid must stay high for NUM consecutive cycles to form a
// frame; a gap before the NUM-th sample discards the frame.
// out_valid is high exactly in the cycles where out_result carries a
// result, and out_result is forced to zero whenever out_valid is low.
// There is no backpressure.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   in_valid   : sample strobe (NUM consecutive cycles per frame)
//   in_number  : unsigned sample, DATA_W bits
//   mode       : 00 alternating sum, 01 max-min, 10 sorted list, 11 deltas
//   out_valid  : result strobe
//   out_result : signed two's-complement result, OUT_W bits
module seq_stat_engine #(
  parameter int DATA_W = 4,
  parameter int NUM    = 6,
  localparam int OUT_W = DATA_W + $clog2(NUM) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_number,
  input  logic [1:0]        mode,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_result
);

  localparam int CNT_W = $clog2(NUM + 1);
  localparam logic [CNT_W-1:0] NUM_C  = CNT_W'(NUM);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NUM - 1);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;       // samples stored so far in this frame
  logic [CNT_W-1:0]  out_idx;   // results already issued in OUT
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] samples    [NUM];  // arrival order
  logic [DATA_W-1:0] sorted     [NUM];  // ascending, stable
  logic [DATA_W-1:0] sorted_ins [NUM];  // sorted with the incoming sample inserted

  logic              accept;
  logic [CNT_W-1:0]  ins_cnt;

  // Samples are only taken while a frame is being collected; anything seen
  // in CALC or OUT is dropped.
  assign accept  = in_valid && (state == IDLE || state == LOAD);
  // The first sample of a frame lands at position 0 regardless of what the
  // counter held from the previous frame.
  assign ins_cnt = (state == LOAD) ? cnt : '0;

  function automatic logic signed [OUT_W-1:0] zext(input logic [DATA_W-1:0] v);
    return {{(OUT_W - DATA_W){1'b0}}, v};
  endfunction

  // Stable insertion: the valid prefix sorted[0..ins_cnt-1] is ascending.
  // Entries <= the new value stay put (so equal values keep arrival order),
  // the new value goes right after them, and larger entries shift up one.
  // Positions beyond the valid prefix are left untouched.
  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      sorted_ins[i] = sorted[i];
    end
    if (ins_cnt != '0 && sorted[0] <= in_number) begin
      sorted_ins[0] = sorted[0];
    end else begin
      sorted_ins[0] = in_number;
    end
    for (int i = 1; i < NUM; i++) begin
      if (CNT_W'(i) <= ins_cnt) begin
        if (CNT_W'(i) < ins_cnt && sorted[i] <= in_number) begin
          sorted_ins[i] = sorted[i];
        end else if (sorted[i-1] > in_number) begin
          sorted_ins[i] = sorted[i-1];
        end else begin
          sorted_ins[i] = in_number;
        end
      end
    end
  end

  // Result datapath. All arithmetic is OUT_W wide, which holds the largest
  // alternating sum (ceil(NUM/2) * max sample) and the most negative delta.
  logic signed [OUT_W-1:0] alt_sum;
  logic signed [OUT_W-1:0] range_val;
  logic signed [OUT_W-1:0] sort_val;
  logic signed [OUT_W-1:0] diff_val;
  logic signed [OUT_W-1:0] next_result;
  logic [CNT_W-1:0]        sel_idx;
  logic [CNT_W-1:0]        n_out;

  always_comb begin
    alt_sum = '0;
    for (int i = 0; i < NUM; i++) begin
      if (i % 2 == 0) begin
        alt_sum = alt_sum + zext(samples[i]);
      end else begin
        alt_sum = alt_sum - zext(samples[i]);
      end
    end

    range_val = zext(sorted[NUM-1]) - zext(sorted[0]);

    // CALC produces result 0; OUT produces result out_idx.
    sel_idx = (state == OUT) ? out_idx : '0;

    sort_val = '0;
    for (int i = 0; i < NUM; i++) begin
      if (sel_idx == CNT_W'(i)) begin
        sort_val = zext(sorted[i]);
      end
    end

    diff_val = '0;
    for (int i = 0; i < NUM - 1; i++) begin
      if (sel_idx == CNT_W'(i)) begin
        diff_val = zext(samples[i+1]) - zext(samples[i]);
      end
    end

    case (mode_q)
      2'b00: begin
        next_result = alt_sum;
        n_out       = ONE_C;
      end
      2'b01: begin
        next_result = range_val;
        n_out       = ONE_C;
      end
      2'b10: begin
        next_result = sort_val;
        n_out       = NUM_C;
      end
      default: begin
        next_result = diff_val;
        n_out       = LAST_C;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      out_idx    <= '0;
      mode_q     <= 2'b00;
      out_valid  <= 1'b0;
      out_result <= '0;
      for (int i = 0; i < NUM; i++) begin
        samples[i] <= '0;
        sorted[i]  <= '0;
      end
    end else begin
      if (accept) begin
        for (int i = 0; i < NUM; i++) begin
          if (ins_cnt == CNT_W'(i)) begin
            samples[i] <= in_number;
          end
          sorted[i] <= sorted_ins[i];
        end
      end

      case (state)
        IDLE: begin
          if (in_valid) begin
            mode_q <= mode;
            cnt    <= ONE_C;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (!in_valid) begin
            // Short frame: drop it silently.
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + ONE_C;
            if (cnt == LAST_C) begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          out_valid  <= 1'b1;
          out_result <= next_result;
          out_idx    <= ONE_C;
          cnt        <= '0;
          state      <= OUT;
        end
        OUT: begin
          if (out_idx == n_out) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_idx    <= '0;
            state      <= IDLE;
          end else begin
            out_result <= next_result;
            out_idx    <= out_idx + ONE_C;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_stat_engine.sv
// Testbench for seq_stat_engine (DATA_W=4, NUM=6).
// Directed frames from the requirements plus randomized frames; a
// reference model computes each frame's results from plain arithmetic and
// pushes them, with the cycle they are due, into a scoreboard queue that a
// negedge monitor drains.
module tb_seq_stat_engine;

  localparam int DATA_W = 4;
  localparam int NUM    = 6;
  localparam int OUT_W  = 8;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [DATA_W-1:0] in_number;
  logic [1:0]        mode;
  logic              out_valid;
  logic [OUT_W-1:0]  out_result;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  seq_stat_engine #(.DATA_W(DATA_W), .NUM(NUM)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_number  (in_number),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_result (out_result)
  );

  // ---------------- scoreboard ----------------
  logic [OUT_W-1:0] exp_q[$];
  int               exp_cyc_q[$];
  int               n_cmp  = 0;
  int               n_fail = 0;
  logic [OUT_W-1:0] mon_e;
  int               mon_ec;

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got result %0d at cycle %0d, required no output",
                 $signed(out_result), cyc);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_ec = exp_cyc_q.pop_front();
        if (out_result !== mon_e || cyc != mon_ec) begin
          n_fail++;
          $display("FAIL result: got %0d at cycle %0d, required %0d at cycle %0d",
                   $signed(out_result), cyc, $signed(mon_e), mon_ec);
        end
      end
    end else begin
      n_cmp++;
      if (out_result !== '0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_result: got valid=%b result=%0d, required valid=0 result=0",
                 out_valid, out_result);
      end
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
        n_cmp++;
        n_fail++;
        $display("FAIL missing_output: got no output at cycle %0d, required %0d",
                 cyc, $signed(exp_q[0]));
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
    end
  end

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] fr [NUM];
  int                last_cyc;

  function automatic int n_out_of(input logic [1:0] m);
    case (m)
      2'b00:   return 1;
      2'b01:   return 1;
      2'b10:   return NUM;
      default: return NUM - 1;
    endcase
  endfunction

  task automatic push_expected(input logic [1:0] m, input int lc);
    int res[$];
    int s;
    int mx;
    int mn;
    int srt[$];
    case (m)
      2'b00: begin
        s = 0;
        for (int k = 0; k < NUM; k++) s += (k % 2 == 0) ? int'(fr[k]) : -int'(fr[k]);
        res.push_back(s);
      end
      2'b01: begin
        mx = 0;
        mn = 1 << DATA_W;
        for (int k = 0; k < NUM; k++) begin
          if (int'(fr[k]) > mx) mx = int'(fr[k]);
          if (int'(fr[k]) < mn) mn = int'(fr[k]);
        end
        res.push_back(mx - mn);
      end
      2'b10: begin
        for (int k = 0; k < NUM; k++) srt.push_back(int'(fr[k]));
        srt.sort();
        foreach (srt[k]) res.push_back(srt[k]);
      end
      default: begin
        for (int k = 1; k < NUM; k++) res.push_back(int'(fr[k]) - int'(fr[k-1]));
      end
    endcase
    foreach (res[k]) begin
      exp_q.push_back(OUT_W'(res[k]));
      exp_cyc_q.push_back(lc + 2 + k);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_frame(input int a0, input int a1, input int a2,
                           input int a3, input int a4, input int a5);
    fr[0] = DATA_W'(a0); fr[1] = DATA_W'(a1); fr[2] = DATA_W'(a2);
    fr[3] = DATA_W'(a3); fr[4] = DATA_W'(a4); fr[5] = DATA_W'(a5);
  endtask

  task automatic random_frame();
    for (int k = 0; k < NUM; k++) fr[k] = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
  endtask

  // Drives len samples; mode is valid only on the first one and random after.
  task automatic drive_samples(input logic [1:0] m, input int len);
    for (int k = 0; k < len; k++) begin
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_number = fr[k];
      mode      = (k == 0) ? m : 2'($urandom_range(0, 3));
    end
    last_cyc = cyc;
  endtask

  // Holds in_valid high for extra cycles (must be ignored), drops it, and
  // waits until the engine is back in IDLE.
  task automatic finish_frame(input logic [1:0] m, input int len, input int extra);
    if (len == NUM) push_expected(m, last_cyc);
    for (int e = 0; e < extra; e++) begin
      @(posedge clk); #1;
      in_number = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
      mode      = 2'($urandom_range(0, 3));
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_number = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
    mode      = 2'($urandom_range(0, 3));
    if (len == NUM) begin
      while (cyc < last_cyc + 1 + n_out_of(m)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic run_frame(input logic [1:0] m, input int len, input int extra);
    drive_samples(m, len);
    finish_frame(m, len, extra);
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if (out_valid !== 1'b0 || out_result !== '0) begin
      n_fail++;
      $display("FAIL %s: got valid=%b result=%0d, required valid=0 result=0",
               name, out_valid, out_result);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int len;
    logic [1:0] m;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_number = '0;
    mode      = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Reference frame in every mode.
    set_frame(3, 9, 1, 15, 0, 7);
    run_frame(2'b00, NUM, 0);   // -27
    run_frame(2'b01, NUM, 0);   // 15
    run_frame(2'b10, NUM, 0);   // 0,1,3,7,9,15
    run_frame(2'b11, NUM, 0);   // 6,-8,14,-15,7
    set_frame(5, 5, 5, 5, 5, 5);
    run_frame(2'b01, NUM, 0);   // 0
    set_frame(4, 2, 4, 2, 4, 2);
    run_frame(2'b10, NUM, 0);   // 2,2,2,4,4,4
    set_frame(15, 0, 15, 0, 15, 0);
    run_frame(2'b11, NUM, 0);   // -15,15,-15,15,-15
    run_frame(2'b00, NUM, 0);   // 45

    // Short frame is discarded, the next full frame is correct.
    set_frame(3, 9, 1, 15, 0, 7);
    run_frame(2'b01, 3, 0);
    @(posedge clk); #1;
    run_frame(2'b01, NUM, 0);

    // in_valid held through CALC and OUT must not start a frame.
    run_frame(2'b00, NUM, 2);
    repeat (2) @(posedge clk);

    // Reset during the 3rd output cycle of a sorted frame.
    drive_samples(2'b10, NUM);
    push_expected(2'b10, last_cyc);
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (cyc < last_cyc + 4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    #1;
    check_zero("reset_mid_out");
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (3) @(negedge clk) check_zero("after_reset_quiet");
    set_frame(3, 9, 1, 15, 0, 7);
    run_frame(2'b11, NUM, 0);

    // Reset during LOAD aborts the frame.
    drive_samples(2'b00, 4);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_frame(1, 2, 3, 4, 5, 6);
    run_frame(2'b00, NUM, 0);

    // Randomized frames.
    for (int f = 0; f < 60; f++) begin
      random_frame();
      m = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        len = $urandom_range(1, NUM - 1);
        run_frame(m, len, 0);
      end else begin
        run_frame(m, NUM, $urandom_range(0, 1));
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (20) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d outputs still pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation timeout, required completion");
    $fatal(1, "timeout");
  end

endmodule
